// File: rtl/vector_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_seq_ctrl_if
// Brief    : Upstream valid/ready instruction handshake into vector_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_seq_ctrl_if;
    logic        vsi_op_valid;
    logic [31:0] vsi_op;
    logic        vsi_op_ready;

    modport master (
        output vsi_op_valid,
        output vsi_op,
        input  vsi_op_ready
    );

    modport slave (
        input  vsi_op_valid,
        input  vsi_op,
        output vsi_op_ready
    );
endinterface
`default_nettype wire

// File: rtl/vector_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vector_seq_ctrl
// Brief    : 2-entry instruction queue, LMUL/SEW config and EXEC->WB sequencer
//            feeding the vector datapath.
// Revision : 1.0 - initial release
// ============================================================================
module vector_seq_ctrl (
    input  wire logic             vsi_clk,
    input  wire logic             vsi_rst_n,
    vector_seq_ctrl_if.slave      vsi,
    output logic [31:0]           op_o,
    output logic                  lmul_o,
    output logic                  sew_o,
    output logic                  exec_en,
    output logic                  write_en,
    output logic                  vsi_done,
    output logic                  vsi_err,
    output logic                  vsi_busy
);

    localparam logic [6:0] c_OPV       = 7'b1010111;
    localparam logic [2:0] c_FUNCT3_CFG = 3'b111;
    localparam logic [2:0] c_FIELD_0   = 3'b000;
    localparam logic [2:0] c_FIELD_1   = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fifo_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        cfg_lmul_q, cfg_lmul_d;
    logic        cfg_sew_q, cfg_sew_d;
    logic [31:0] op_q, op_d;
    logic        lmul_q, lmul_d;
    logic        sew_q, sew_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] w_head;
    logic        w_push, w_pop;
    logic        w_is_opv, w_is_cfg, w_is_arith, w_cfg_legal;
    logic        w_lmul_ok, w_sew_ok;

    assign vsi.vsi_op_ready = (count_q != 2'd2);
    assign w_push           = vsi.vsi_op_valid && vsi.vsi_op_ready;
    assign w_head           = fifo_q[rd_ptr_q];

    assign w_is_opv    = (w_head[6:0] == c_OPV);
    assign w_is_cfg    = w_is_opv && (w_head[14:12] == c_FUNCT3_CFG);
    assign w_is_arith  = w_is_opv && !w_is_cfg;
    assign w_lmul_ok   = (w_head[22:20] == c_FIELD_0) || (w_head[22:20] == c_FIELD_1);
    assign w_sew_ok    = (w_head[25:23] == c_FIELD_0) || (w_head[25:23] == c_FIELD_1);
    assign w_cfg_legal = w_is_cfg && w_lmul_ok && w_sew_ok;

    always_comb begin
        state_d    = state_q;
        w_pop      = 1'b0;
        cfg_lmul_d = cfg_lmul_q;
        cfg_sew_d  = cfg_sew_q;
        op_d       = op_q;
        lmul_d     = lmul_q;
        sew_d      = sew_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 2'd0) begin
                    w_pop = 1'b1;
                    if (w_is_arith) begin
                        op_d    = w_head;
                        lmul_d  = cfg_lmul_q;
                        sew_d   = cfg_sew_q;
                        state_d = S_EXEC;
                    end else if (w_cfg_legal) begin
                        cfg_lmul_d = (w_head[22:20] == c_FIELD_1);
                        cfg_sew_d  = (w_head[25:23] == c_FIELD_1);
                        done_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                // A non-arithmetic head waits for IDLE so its done/err pulse
                // lands in its own cycle instead of merging with this retire.
                if ((count_q != 2'd0) && w_is_arith) begin
                    w_pop   = 1'b1;
                    op_d    = w_head;
                    lmul_d  = cfg_lmul_q;
                    sew_d   = cfg_sew_q;
                    state_d = S_EXEC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            cfg_lmul_q <= 1'b0;
            cfg_sew_q  <= 1'b0;
            op_q       <= 32'd0;
            lmul_q     <= 1'b0;
            sew_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cfg_lmul_q <= cfg_lmul_d;
            cfg_sew_q  <= cfg_sew_d;
            op_q       <= op_d;
            lmul_q     <= lmul_d;
            sew_q      <= sew_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (w_push) wr_ptr_q <= ~wr_ptr_q;
            if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Queue storage carries no reset; occupancy is governed by count_q.
    always_ff @(posedge vsi_clk) begin
        if (w_push) fifo_q[wr_ptr_q] <= vsi.vsi_op;
    end

    assign op_o     = op_q;
    assign lmul_o   = lmul_q;
    assign sew_o    = sew_q;
    assign exec_en  = (state_q == S_EXEC) || (state_q == S_WB);
    assign write_en = (state_q == S_WB);
    assign vsi_done = done_q;
    assign vsi_err  = err_q;
    assign vsi_busy = (state_q != S_IDLE) || (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_vector_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_seq_ctrl
// Brief    : Directed self-checking bench for vector_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_seq_ctrl;

    localparam logic [31:0] c_VXOR    = 32'h2E20C057;
    localparam logic [31:0] c_ARITH_B = 32'h0420C057;
    localparam logic [31:0] c_CFG_11  = 32'h01207057;
    localparam logic [31:0] c_CFG_BAD = 32'h01A07057;
    localparam logic [31:0] c_CFG_10  = 32'h00207057;
    localparam logic [31:0] c_ILL     = 32'h00000013;
    localparam logic [31:0] c_W0      = 32'h02000057;
    localparam logic [31:0] c_W1      = 32'h04000057;
    localparam logic [31:0] c_W2      = 32'h06000057;
    localparam logic [31:0] c_W3      = 32'h08000057;

    logic        clk;
    logic        rst_n;
    logic [31:0] op_o;
    logic        lmul_o, sew_o, exec_en, write_en, vsi_done, vsi_err, vsi_busy;
    int          errors;
    int          checks;

    vector_seq_ctrl_if vsi_if ();

    vector_seq_ctrl u_dut (
        .vsi_clk   (clk),
        .vsi_rst_n (rst_n),
        .vsi       (vsi_if.slave),
        .op_o      (op_o),
        .lmul_o    (lmul_o),
        .sew_o     (sew_o),
        .exec_en   (exec_en),
        .write_en  (write_en),
        .vsi_done  (vsi_done),
        .vsi_err   (vsi_err),
        .vsi_busy  (vsi_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pipe(input string tag, input logic e_exec, input logic e_wr,
                            input logic [31:0] e_op, input logic e_done);
        chk({tag, ".exec_en"},  {31'd0, exec_en},  {31'd0, e_exec});
        chk({tag, ".write_en"}, {31'd0, write_en}, {31'd0, e_wr});
        chk({tag, ".op_o"},     op_o,              e_op);
        chk({tag, ".done"},     {31'd0, vsi_done}, {31'd0, e_done});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        vsi_if.vsi_op_valid = 1'b0;
        vsi_if.vsi_op       = 32'd0;

        // Reset state
        step(); step();
        chk_pipe("rst", 1'b0, 1'b0, 32'd0, 1'b0);
        chk("rst.lmul",  {31'd0, lmul_o},              32'd0);
        chk("rst.sew",   {31'd0, sew_o},               32'd0);
        chk("rst.err",   {31'd0, vsi_err},             32'd0);
        chk("rst.busy",  {31'd0, vsi_busy},            32'd0);
        chk("rst.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd1);
        rst_n = 1'b1;
        step();
        chk("rel.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd1);
        chk("rel.busy",  {31'd0, vsi_busy},            32'd0);

        // Single ARITH
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_VXOR;
        step();
        vsi_if.vsi_op_valid = 1'b0; vsi_if.vsi_op = 32'd0;
        chk("s1_e0.busy", {31'd0, vsi_busy}, 32'd1);
        chk("s1_e0.exec", {31'd0, exec_en},  32'd0);
        step();
        chk_pipe("s1_e1", 1'b1, 1'b0, c_VXOR, 1'b0);
        chk("s1_e1.lmul", {31'd0, lmul_o}, 32'd0);
        chk("s1_e1.sew",  {31'd0, sew_o},  32'd0);
        step();
        chk_pipe("s1_e2", 1'b1, 1'b1, c_VXOR, 1'b0);
        step();
        chk_pipe("s1_e3", 1'b0, 1'b0, c_VXOR, 1'b1);
        chk("s1_e3.busy", {31'd0, vsi_busy}, 32'd0);
        step();
        chk("s1_e4.done", {31'd0, vsi_done}, 32'd0);

        // Config 1/1 then ARITH
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_CFG_11;
        step();
        vsi_if.vsi_op = c_ARITH_B;
        step();
        vsi_if.vsi_op_valid = 1'b0;
        chk("cfg_e1.done", {31'd0, vsi_done}, 32'd1);
        chk("cfg_e1.exec", {31'd0, exec_en},  32'd0);
        step();
        chk_pipe("cfg_e2", 1'b1, 1'b0, c_ARITH_B, 1'b0);
        chk("cfg_e2.lmul", {31'd0, lmul_o}, 32'd1);
        chk("cfg_e2.sew",  {31'd0, sew_o},  32'd1);
        step();
        chk("cfg_e3.write", {31'd0, write_en}, 32'd1);
        step();
        chk("cfg_e4.done", {31'd0, vsi_done}, 32'd1);
        step();

        // Illegal vsew keeps config at 1/1
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_CFG_BAD;
        step();
        vsi_if.vsi_op_valid = 1'b0;
        step();
        chk("badcfg.err",  {31'd0, vsi_err},  32'd1);
        chk("badcfg.done", {31'd0, vsi_done}, 32'd0);
        chk("badcfg.exec", {31'd0, exec_en},  32'd0);
        step();
        chk("badcfg.err_clr", {31'd0, vsi_err}, 32'd0);
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_VXOR;
        step();
        vsi_if.vsi_op_valid = 1'b0;
        step();
        chk("keep.lmul", {31'd0, lmul_o}, 32'd1);
        chk("keep.sew",  {31'd0, sew_o},  32'd1);
        chk("keep.op",   op_o,            c_VXOR);
        step(); step(); step();

        // Back-to-back, queue fills
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_W0;
        step();
        vsi_if.vsi_op = c_W1;
        chk("b2b_e0.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd1);
        step();
        vsi_if.vsi_op = c_W2;
        chk_pipe("b2b_e1", 1'b1, 1'b0, c_W0, 1'b0);
        chk("b2b_e1.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd1);
        step();
        vsi_if.vsi_op = c_W3;
        chk_pipe("b2b_e2", 1'b1, 1'b1, c_W0, 1'b0);
        chk("b2b_e2.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd0);
        step();
        chk_pipe("b2b_e3", 1'b1, 1'b0, c_W1, 1'b1);
        chk("b2b_e3.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd1);
        step();
        vsi_if.vsi_op_valid = 1'b0;
        chk_pipe("b2b_e4", 1'b1, 1'b1, c_W1, 1'b0);
        chk("b2b_e4.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd0);
        step();
        chk_pipe("b2b_e5", 1'b1, 1'b0, c_W2, 1'b1);
        step();
        chk_pipe("b2b_e6", 1'b1, 1'b1, c_W2, 1'b0);
        step();
        chk_pipe("b2b_e7", 1'b1, 1'b0, c_W3, 1'b1);
        step();
        chk_pipe("b2b_e8", 1'b1, 1'b1, c_W3, 1'b0);
        step();
        chk_pipe("b2b_e9", 1'b0, 1'b0, c_W3, 1'b1);
        chk("b2b_e9.busy", {31'd0, vsi_busy}, 32'd0);
        chk("b2b_e9.lmul", {31'd0, lmul_o},   32'd1);
        step();

        // Reset asserted during WB with a second entry queued
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_W0;
        step();
        vsi_if.vsi_op = c_W1;
        step();
        vsi_if.vsi_op_valid = 1'b0;
        step();
        chk("rwb.write_before", {31'd0, write_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rwb.write", {31'd0, write_en}, 32'd0);
        chk("rwb.exec",  {31'd0, exec_en},  32'd0);
        chk("rwb.busy",  {31'd0, vsi_busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rwb_rel.done",  {31'd0, vsi_done},            32'd0);
        chk("rwb_rel.busy",  {31'd0, vsi_busy},            32'd0);
        chk("rwb_rel.ready", {31'd0, vsi_if.vsi_op_ready}, 32'd1);
        chk("rwb_rel.exec",  {31'd0, exec_en},             32'd0);

        // Config queued behind ARITH only affects later ARITH
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_W2;
        step();
        vsi_if.vsi_op = c_CFG_10;
        step();
        vsi_if.vsi_op_valid = 1'b0;
        chk_pipe("ord_e1", 1'b1, 1'b0, c_W2, 1'b0);
        chk("ord_e1.lmul", {31'd0, lmul_o}, 32'd0);
        chk("ord_e1.sew",  {31'd0, sew_o},  32'd0);
        step();
        chk_pipe("ord_e2", 1'b1, 1'b1, c_W2, 1'b0);
        chk("ord_e2.lmul", {31'd0, lmul_o}, 32'd0);
        step();
        chk_pipe("ord_e3", 1'b0, 1'b0, c_W2, 1'b1);
        chk("ord_e3.busy", {31'd0, vsi_busy}, 32'd1);
        step();
        chk("ord_e4.done", {31'd0, vsi_done}, 32'd1);
        chk("ord_e4.exec", {31'd0, exec_en},  32'd0);
        chk("ord_e4.busy", {31'd0, vsi_busy}, 32'd0);
        step();
        chk("ord_e5.done", {31'd0, vsi_done}, 32'd0);
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_VXOR;
        step();
        vsi_if.vsi_op_valid = 1'b0;
        step();
        chk("ord_next.lmul", {31'd0, lmul_o}, 32'd1);
        chk("ord_next.sew",  {31'd0, sew_o},  32'd0);
        chk("ord_next.op",   op_o,            c_VXOR);
        step(); step(); step();

        // Illegal opcode
        vsi_if.vsi_op_valid = 1'b1; vsi_if.vsi_op = c_ILL;
        step();
        vsi_if.vsi_op_valid = 1'b0;
        step();
        chk("ill.err",  {31'd0, vsi_err},  32'd1);
        chk("ill.exec", {31'd0, exec_en},  32'd0);
        chk("ill.done", {31'd0, vsi_done}, 32'd0);
        chk("ill.op",   op_o,              c_VXOR);
        step();
        chk("ill.err_clr", {31'd0, vsi_err},  32'd0);
        chk("ill.busy",    {31'd0, vsi_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_seq_ctrl.md
# vector_seq_ctrl

Control/sequencing stage directly upstream of the vector datapath. It accepts 32-bit vector instructions over a valid/ready handshake into a 2-entry queue and holds the active configuration (LMUL, SEW) set by vsetvli-class instructions. For each arithmetic instruction it drives the datapath's `op_i`/`lmul_i`/`sew_i` stably and sequences `exec_en`/`write_en` through a fixed EXEC→WB pair of cycles. It also reports completion and illegal-instruction errors.

## Interface
- No parameters; queue depth fixed at 2, instruction width fixed at 32.
- `vsi_clk` in 1: sole clock; all state updates on the rising edge.
- `vsi_rst_n` in 1: asynchronous, active-low reset.
- `vsi_op_valid` in 1: upstream instruction valid.
- `vsi_op` in 32: instruction word; sampled when valid & ready.
- `vsi_op_ready` out 1: `count != 2`; combinational from the registered queue count.
- `op_o` out 32: instruction in flight; to datapath `op_i`.
- `lmul_o` out 1: 0 = 1 register per operand, 1 = 4-register group; to datapath `lmul_i`.
- `sew_o` out 1: 0 = int8, 1 = int32; to datapath `sew_i`.
- `exec_en` out 1: datapath execute enable.
- `write_en` out 1: datapath register-file write enable.
- `vsi_done` out 1: one-cycle pulse per retired instruction, arithmetic or config.
- `vsi_err` out 1: one-cycle pulse per rejected instruction.
- `vsi_busy` out 1: `state != IDLE || count != 0`.

## Operation
- **Queue**
  - 2-entry FIFO with wrap-around read and write pointers and a 2-bit count.
  - Push when `vsi_op_valid && vsi_op_ready`.
  - Push and pop in the same cycle at count 1 leaves count at 1; the new entry follows the popped one.
  - Push at count 2 is impossible because ready is low.
- **Classification of the queue head**
  - OP-V: `[6:0] == 7'b1010111`. Anything else is illegal.
  - CFG: OP-V with `funct3 [14:12] == 3'b111`. Field `vlmul [22:20]`: `000` → lmul 0, `010` → lmul 1. Field `vsew [25:23]`: `000` → sew 0, `010` → sew 1. Any other vlmul or vsew value is illegal.
  - ARITH: any other OP-V instruction. This block does no further funct6 checking; the datapath decodes it.
- **Config registers** `cfg_lmul`, `cfg_sew`
  - Reset to 0/0.
  - Written only when a legal CFG instruction is popped.
  - Unchanged by an illegal CFG instruction.
- **FSM**: states IDLE, EXEC, WB.
  - Pops happen only in IDLE or WB, and only when `count != 0`.
  - Pop ARITH: latch `op_o ← head`, `lmul_o ← cfg_lmul`, `sew_o ← cfg_sew`; go to EXEC.
  - Pop CFG (legal): update config, pulse `vsi_done`; go to IDLE.
  - Pop illegal: pulse `vsi_err`, no `vsi_done`; go to IDLE. `op_o`, `lmul_o`, `sew_o` stay unchanged.
  - EXEC: `exec_en = 1`, `write_en = 0`; go to WB unconditionally.
  - WB: `exec_en = 1`, `write_en = 1`. Pulse `vsi_done` on leaving WB. In the same edge, pop the next entry if present (back-to-back); otherwise go to IDLE.
  - In IDLE: `exec_en = write_en = 0`.
- **Operand stability**: `op_o`, `lmul_o` and `sew_o` are constant for the whole EXEC+WB pair. A CFG instruction queued behind an ARITH instruction affects only later ARITH instructions.
- **Registered outputs**: `exec_en` and `write_en` are decoded from the registered state; `vsi_done` and `vsi_err` are registered.

## Timing
- **Reset values** (asynchronous, immediate on `vsi_rst_n` low):
  - Internal: state IDLE, count 0, pointers 0, config 0/0.
  - Outputs: `op_o = 0`, `lmul_o = 0`, `sew_o = 0`, `exec_en = 0`, `write_en = 0`, `vsi_done = 0`, `vsi_err = 0`, `vsi_busy = 0`, `vsi_op_ready = 1`.
- **ARITH latency**, with the handshake at edge E0:
  - Queue entry visible after E0; pop at E1.
  - EXEC cycle between E1 and E2.
  - WB cycle between E2 and E3 (`write_en` high).
  - `vsi_done` high in the cycle after E3.
- **Throughput**: back-to-back ARITH instructions sustain 1 instruction per 2 cycles; `exec_en` stays continuously high.
- **CFG latency**: popped at E1; `vsi_done` high in the cycle after E1; new config is visible to an ARITH instruction popped at E2 or later.
- **Illegal latency**: `vsi_err` high in the cycle after the pop edge.
- **Reset mid-operation**: the in-flight instruction and queued entries are dropped with no `vsi_done`; `write_en` falls asynchronously.

## Test plan
- **Reset**: assert `vsi_rst_n` during WB → `write_en`, `exec_en` go 0 immediately. After release: `vsi_op_ready = 1`, `vsi_busy = 0`, and no `vsi_done` pulse.
- **Single ARITH**: push vxor `0x2E20C057` at E0 → `exec_en` high after E1 and E2, `write_en` high only after E2, `op_o = 0x2E20C057` throughout, `lmul_o = 0`, `sew_o = 0`, `vsi_done` pulse after E3.
- **Config then ARITH**: push CFG with vlmul `010`, vsew `010`, then ARITH → CFG `vsi_done` pulse; ARITH sees `lmul_o = 1`, `sew_o = 1`. Then push CFG with vsew `011` → `vsi_err` pulse and config stays 1/1.
- **Back-to-back and full queue**: hold valid with 4 ARITH instructions → ready drops at count 2, `exec_en` stays continuously high for 8 cycles, `write_en` alternates 0/1, 4 `vsi_done` pulses, order preserved.
- **Config ordering**: queue ARITH A then CFG (lmul 1) → A executes with `lmul_o = 0`; the CFG `vsi_done` follows the WB-exit `vsi_done` of A by one cycle.
- **Illegal opcode**: push `0x00000013` → `vsi_err` pulse, no `exec_en`, `op_o` unchanged.
